// File: rtl/ldpc_3gpp_dec_llr_read_ctrl_if.sv
// Shared types and the control/strobe interface of the LLR read sequencer.
// LDPC_3GPP_DEC_LLR_READ_CTRL_STALL_EN adds the ihold stall input.
package ldpc_3gpp_dec_llr_read_ctrl_pkg;

    localparam int unsigned ZC_W = 9;

    typedef logic [ZC_W-1:0] hb_zc_t;

    // Read framing strobes; all zero when no read is issued
    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

endpackage

interface ldpc_3gpp_dec_llr_read_ctrl_if #(
    parameter int unsigned pROW_W        = 7,
    parameter int unsigned pROW_BY_CYCLE = 8
);
    import ldpc_3gpp_dec_llr_read_ctrl_pkg::*;

    localparam int unsigned LANE_W = $clog2(pROW_BY_CYCLE) + 1;

    logic                     istart;
    logic                     ic_nv_mode;
    hb_zc_t                   iused_zc;
    logic [pROW_W-1:0]        irow_num;
    logic [LANE_W-1:0]        ilanes;
`ifdef LDPC_3GPP_DEC_LLR_READ_CTRL_STALL_EN
    logic                     ihold;
`endif
    logic                     oread;
    logic                     orstart;
    strb_t                    orstrb;
    logic [pROW_BY_CYCLE-1:0] omask;
    logic                     ocnode_mode;
    logic                     obusy;
    logic                     odone;

    modport master (
        output istart, ic_nv_mode, iused_zc, irow_num, ilanes,
`ifdef LDPC_3GPP_DEC_LLR_READ_CTRL_STALL_EN
        output ihold,
`endif
        input  oread, orstart, orstrb, omask, ocnode_mode, obusy, odone
    );

    modport slave (
        input  istart, ic_nv_mode, iused_zc, irow_num, ilanes,
`ifdef LDPC_3GPP_DEC_LLR_READ_CTRL_STALL_EN
        input  ihold,
`endif
        output oread, orstart, orstrb, omask, ocnode_mode, obusy, odone
    );

endinterface

// File: rtl/ldpc_3gpp_dec_llr_read_ctrl.sv
// LLR read sequencer: walks seg_num x seg_len read words for one decoder pass, then drains 4 cycles.
// Optional stall input enabled by LDPC_3GPP_DEC_LLR_READ_CTRL_STALL_EN.
module ldpc_3gpp_dec_llr_read_ctrl
    import ldpc_3gpp_dec_llr_read_ctrl_pkg::*;
#(
    parameter int unsigned pROW_W        = 7,
    parameter int unsigned pROW_BY_CYCLE = 8
) (
    input  logic iclk,
    input  logic ireset,
    input  logic iclkena,
    ldpc_3gpp_dec_llr_read_ctrl_if.slave bus
);

    localparam int unsigned LANE_W = $clog2(pROW_BY_CYCLE) + 1;
    localparam int unsigned CNT_W  = (ZC_W > pROW_W) ? ZC_W : pROW_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_w, w_w_nxt;
    logic [CNT_W-1:0]         r_s, w_s_nxt;
    logic [CNT_W-1:0]         r_seg_len, w_len_nxt;
    logic [CNT_W-1:0]         r_seg_num, w_num_nxt;
    logic                     r_last, w_last_nxt;
    logic [1:0]               r_dcnt, w_dcnt_nxt;
    logic                     r_oread, w_oread_nxt;
    logic                     r_orstart, w_orstart_nxt;
    strb_t                    r_orstrb, w_orstrb_nxt;
    logic [pROW_BY_CYCLE-1:0] r_omask, w_omask_nxt;
    logic                     r_cnode, w_cnode_nxt;
    logic                     r_obusy, w_obusy_nxt;
    logic                     r_odone, w_odone_nxt;

    logic [CNT_W-1:0]         w_in_len, w_in_num;
    logic [CNT_W-1:0]         w_cur_w, w_cur_s, w_len, w_num;
    logic [pROW_BY_CYCLE-1:0] w_lane_mask;
    logic                     w_issue, w_sop, w_eop, w_hold;

`ifdef LDPC_3GPP_DEC_LLR_READ_CTRL_STALL_EN
    assign w_hold = bus.ihold;
`else
    assign w_hold = 1'b0;
`endif

    // Geometry and lane mask derived from the live config inputs (used only at accept)
    always_comb begin
        w_in_len = bus.ic_nv_mode ? CNT_W'(bus.iused_zc) : CNT_W'(bus.irow_num);
        w_in_num = bus.ic_nv_mode ? CNT_W'(bus.irow_num) : CNT_W'(bus.iused_zc);
        w_lane_mask = '0;
        for (int i = 0; i < int'(pROW_BY_CYCLE); i++) begin
            w_lane_mask[i] = (LANE_W'(i) < bus.ilanes);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_w_nxt       = r_w;
        w_s_nxt       = r_s;
        w_len_nxt     = r_seg_len;
        w_num_nxt     = r_seg_num;
        w_last_nxt    = r_last;
        w_dcnt_nxt    = r_dcnt;
        w_omask_nxt   = r_omask;
        w_cnode_nxt   = r_cnode;
        w_obusy_nxt   = r_obusy;
        w_oread_nxt   = 1'b0;
        w_orstart_nxt = 1'b0;
        w_orstrb_nxt  = '0;
        w_odone_nxt   = 1'b0;
        w_issue       = 1'b0;
        w_cur_w       = r_w;
        w_cur_s       = r_s;
        w_len         = r_seg_len;
        w_num         = r_seg_num;
        w_sop         = 1'b0;
        w_eop         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.istart) begin
                    w_len_nxt   = w_in_len;
                    w_num_nxt   = w_in_num;
                    w_cnode_nxt = bus.ic_nv_mode;
                    w_omask_nxt = w_lane_mask;
                    w_obusy_nxt = 1'b1;
                    w_dcnt_nxt  = '0;
                    w_last_nxt  = 1'b0;
                    if ((w_in_len != '0) && (w_in_num != '0)) begin
                        // First word leaves with the accept so oread follows istart by one cycle
                        w_state_nxt   = ST_RUN;
                        w_issue       = 1'b1;
                        w_orstart_nxt = 1'b1;
                        w_cur_w       = '0;
                        w_cur_s       = '0;
                        w_len         = w_in_len;
                        w_num         = w_in_num;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_RUN: begin
                if (r_last) begin
                    w_state_nxt = ST_DRAIN;
                    w_dcnt_nxt  = '0;
                    w_last_nxt  = 1'b0;
                end else if (!w_hold) begin
                    w_issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_dcnt_nxt = r_dcnt + 2'd1;
                if (r_dcnt == 2'd2) begin
                    w_odone_nxt = 1'b1;
                end
                if (r_dcnt == 2'd3) begin
                    w_state_nxt = ST_IDLE;
                    w_obusy_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Framing for the issued word and counter advance
        if (w_issue) begin
            w_sop            = (w_cur_w == '0);
            w_eop            = (w_cur_w == (w_len - CNT_W'(1)));
            w_oread_nxt      = 1'b1;
            w_orstrb_nxt.sop = w_sop;
            w_orstrb_nxt.eop = w_eop;
            w_orstrb_nxt.sof = w_sop && (w_cur_s == '0);
            w_orstrb_nxt.eof = w_eop && (w_cur_s == (w_num - CNT_W'(1)));
            w_last_nxt       = w_orstrb_nxt.eof;
            if (w_eop) begin
                w_w_nxt = '0;
                w_s_nxt = w_cur_s + CNT_W'(1);
            end else begin
                w_w_nxt = w_cur_w + CNT_W'(1);
                w_s_nxt = w_cur_s;
            end
        end
    end

    // State and output registers; reset wins over clock enable
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state   <= ST_IDLE;
            r_w       <= '0;
            r_s       <= '0;
            r_seg_len <= '0;
            r_seg_num <= '0;
            r_last    <= 1'b0;
            r_dcnt    <= '0;
            r_oread   <= 1'b0;
            r_orstart <= 1'b0;
            r_orstrb  <= '0;
            r_omask   <= '0;
            r_cnode   <= 1'b0;
            r_obusy   <= 1'b0;
            r_odone   <= 1'b0;
        end else if (iclkena) begin
            r_state   <= w_state_nxt;
            r_w       <= w_w_nxt;
            r_s       <= w_s_nxt;
            r_seg_len <= w_len_nxt;
            r_seg_num <= w_num_nxt;
            r_last    <= w_last_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_oread   <= w_oread_nxt;
            r_orstart <= w_orstart_nxt;
            r_orstrb  <= w_orstrb_nxt;
            r_omask   <= w_omask_nxt;
            r_cnode   <= w_cnode_nxt;
            r_obusy   <= w_obusy_nxt;
            r_odone   <= w_odone_nxt;
        end
    end

    assign bus.oread       = r_oread;
    assign bus.orstart     = r_orstart;
    assign bus.orstrb      = r_orstrb;
    assign bus.omask       = r_omask;
    assign bus.ocnode_mode = r_cnode;
    assign bus.obusy       = r_obusy;
    assign bus.odone       = r_odone;

endmodule
